// File: rtl/fun_sch_if.sv
// Issue/completion bundle between the scheduler and the functional units.
interface fun_sch_if #(
   parameter int PRG_IDX_BITS  = 6,
   parameter int PRG_SIG_WIDTH = 7
);
   logic [3:0]                 iss_vld;
   logic [4*PRG_IDX_BITS-1:0]  iss_prg;
   logic [PRG_SIG_WIDTH-1:0]   fls_frm_rob;
   logic                       mem_ack;
   logic [3:0]                 fun_rdy_frm_exe;
   logic [4*PRG_SIG_WIDTH-1:0] prg_rdy_frm_exe;

   modport master (output iss_vld, iss_prg, fls_frm_rob, mem_ack,
                   input  fun_rdy_frm_exe, prg_rdy_frm_exe);
   modport slave  (input  iss_vld, iss_prg, fls_frm_rob, mem_ack,
                   output fun_rdy_frm_exe, prg_rdy_frm_exe);
endinterface

// File: rtl/fun_sch.sv
// Functional-unit scheduler: mult (fixed latency), two ALUs (1 cycle), addr (waits mem_ack).
// FUN_SCH_MUL_EARLY_RDY_EN: mult ready reasserts together with its completion pulse.
module fun_sch #(
   parameter int PRG_IDX_BITS  = 6,
   parameter int PRG_SIG_WIDTH = 7,
   parameter int MUL_LAT       = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   fun_sch_if.slave   bus
);
   localparam int IW = PRG_IDX_BITS;
`ifdef FUN_SCH_MUL_EARLY_RDY_EN
   localparam logic MUL_EARLY = 1'b1;
`else
   localparam logic MUL_EARLY = 1'b0;
`endif

   typedef enum logic {M_IDLE, M_BUSY} mst_e;
   typedef enum logic {A_IDLE, A_WAIT} ast_e;

   mst_e                     mst_q;
   ast_e                     ast_q;
   logic [3:0]               cnt_q;
   logic [IW-1:0]            mpreg_q, apreg_q;
   logic                     mul_rdy_q, alu_rdy_q, adr_rdy_q;
   logic [PRG_SIG_WIDTH-1:0] mul_slot_q, adr_slot_q;
   logic [2:1][PRG_SIG_WIDTH-1:0] alu_slot_q;
   logic [3:0]               rdy, acc;
   logic                     fls;
   logic                     unused_fls_idx;

   assign fls            = bus.fls_frm_rob[PRG_SIG_WIDTH-1];
   assign unused_fls_idx = ^bus.fls_frm_rob[PRG_SIG_WIDTH-2:0];
   assign rdy            = {adr_rdy_q, alu_rdy_q, alu_rdy_q, mul_rdy_q};
   // a flush cycle accepts nothing
   assign acc            = bus.iss_vld & rdy & {4{~fls}};

   assign bus.fun_rdy_frm_exe = rdy;
   assign bus.prg_rdy_frm_exe = {adr_slot_q, alu_slot_q[2], alu_slot_q[1], mul_slot_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) alu_rdy_q <= 1'b0;
      else        alu_rdy_q <= 1'b1;
   end

   for (genvar k = 1; k <= 2; k++) begin : g_alu
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)      alu_slot_q[k] <= '0;
         else if (acc[k]) alu_slot_q[k] <= {1'b1, bus.iss_prg[k*IW +: IW]};
         else             alu_slot_q[k] <= '0;
      end
   end

   // Pulse leaves as the counter reaches zero, so slot0 lands MUL_LAT cycles after issue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mst_q      <= M_IDLE;
         cnt_q      <= '0;
         mpreg_q    <= '0;
         mul_rdy_q  <= 1'b0;
         mul_slot_q <= '0;
      end else begin
         mul_slot_q <= '0;
         if (fls) begin
            mst_q     <= M_IDLE;
            cnt_q     <= '0;
            mul_rdy_q <= 1'b1;
         end else begin
            case (mst_q)
               M_IDLE: begin
                  if (acc[0]) begin
                     mpreg_q   <= bus.iss_prg[0 +: IW];
                     cnt_q     <= 4'(MUL_LAT - 1);
                     mst_q     <= M_BUSY;
                     mul_rdy_q <= 1'b0;
                  end else begin
                     mul_rdy_q <= 1'b1;
                  end
               end
               M_BUSY: begin
                  if (cnt_q == 4'd1) begin
                     cnt_q      <= '0;
                     mst_q      <= M_IDLE;
                     mul_slot_q <= {1'b1, mpreg_q};
                     mul_rdy_q  <= MUL_EARLY;
                  end else begin
                     cnt_q <= cnt_q - 4'd1;
                  end
               end
               default: mst_q <= M_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ast_q      <= A_IDLE;
         apreg_q    <= '0;
         adr_rdy_q  <= 1'b0;
         adr_slot_q <= '0;
      end else begin
         adr_slot_q <= '0;
         if (fls) begin
            ast_q     <= A_IDLE;
            adr_rdy_q <= 1'b1;
         end else begin
            case (ast_q)
               A_IDLE: begin
                  if (acc[3]) begin
                     apreg_q   <= bus.iss_prg[3*IW +: IW];
                     ast_q     <= A_WAIT;
                     adr_rdy_q <= 1'b0;
                  end else begin
                     adr_rdy_q <= 1'b1;
                  end
               end
               A_WAIT: begin
                  if (bus.mem_ack) begin
                     ast_q      <= A_IDLE;
                     adr_slot_q <= {1'b1, apreg_q};
                     adr_rdy_q  <= 1'b1;
                  end
               end
               default: ast_q <= A_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_fun_sch.sv
// Directed self-checking bench for fun_sch (MUL_LAT=3, 6-bit preg, 7-bit slots).
module tb_fun_sch;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   fun_sch_if #(.PRG_IDX_BITS(6), .PRG_SIG_WIDTH(7)) bus ();
   fun_sch #(.PRG_IDX_BITS(6), .PRG_SIG_WIDTH(7), .MUL_LAT(3)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk); #1;
   endtask

   function automatic logic [6:0] slot(input int k);
      return bus.prg_rdy_frm_exe[k*7 +: 7];
   endfunction

   task automatic idle_inputs();
      bus.iss_vld = 4'b0; bus.iss_prg = '0; bus.fls_frm_rob = '0; bus.mem_ack = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      step();
      n_cmp++; if (bus.fun_rdy_frm_exe !== 4'b0000) begin n_bad++; $display("FAIL rst_rdy got %b want 0000", bus.fun_rdy_frm_exe); end
      n_cmp++; if (bus.prg_rdy_frm_exe !== 28'h0) begin n_bad++; $display("FAIL rst_prg got %h want 0", bus.prg_rdy_frm_exe); end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (bus.fun_rdy_frm_exe !== 4'b1111) begin n_bad++; $display("FAIL rel_rdy[%0d] got %b want 1111", i, bus.fun_rdy_frm_exe); end
         n_cmp++; if (bus.prg_rdy_frm_exe !== 28'h0) begin n_bad++; $display("FAIL rel_prg[%0d] got %h want 0", i, bus.prg_rdy_frm_exe); end
      end
   endtask

   task automatic test_alu();
      bus.iss_vld = 4'b0110; bus.iss_prg = {6'd0, 6'd9, 6'd5, 6'd0};
      step();
      idle_inputs();
      n_cmp++; if (slot(1) !== 7'h45) begin n_bad++; $display("FAIL alu1 got %h want 45", slot(1)); end
      n_cmp++; if (slot(2) !== 7'h49) begin n_bad++; $display("FAIL alu2 got %h want 49", slot(2)); end
      n_cmp++; if (slot(0) !== 7'h0 || slot(3) !== 7'h0) begin n_bad++; $display("FAIL alu_other got %h/%h want 0/0", slot(0), slot(3)); end
      step();
      n_cmp++; if (bus.prg_rdy_frm_exe !== 28'h0) begin n_bad++; $display("FAIL alu_pulse got %h want 0", bus.prg_rdy_frm_exe); end
   endtask

   task automatic test_mult();
      logic [6:0] exp_s [1:5];
      logic       exp_r [1:5];
      exp_s = '{7'h0, 7'h0, 7'h4C, 7'h0, 7'h0};
`ifdef FUN_SCH_MUL_EARLY_RDY_EN
      exp_r = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`else
      exp_r = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`endif
      bus.iss_vld = 4'b0001; bus.iss_prg = {18'd0, 6'd12};
      for (int t = 1; t <= 5; t++) begin
         step();
         if (t == 1) bus.iss_prg = {18'd0, 6'd7};
         else idle_inputs();
         n_cmp++; if (slot(0) !== exp_s[t]) begin n_bad++; $display("FAIL mul_slot T+%0d got %h want %h", t, slot(0), exp_s[t]); end
         n_cmp++; if (bus.fun_rdy_frm_exe[0] !== exp_r[t]) begin n_bad++; $display("FAIL mul_rdy T+%0d got %b want %b", t, bus.fun_rdy_frm_exe[0], exp_r[t]); end
      end
   endtask

   task automatic test_addr();
      bus.iss_vld = 4'b1000; bus.iss_prg = {6'd33, 18'd0};
      for (int t = 1; t <= 4; t++) begin
         step();
         idle_inputs();
         if (t == 4) bus.mem_ack = 1'b1;
         n_cmp++; if (bus.fun_rdy_frm_exe[3] !== 1'b0 || slot(3) !== 7'h0) begin n_bad++; $display("FAIL adr_wait T+%0d got rdy=%b slot=%h want 0/00", t, bus.fun_rdy_frm_exe[3], slot(3)); end
      end
      step();
      idle_inputs();
      n_cmp++; if (slot(3) !== 7'h61) begin n_bad++; $display("FAIL adr_slot got %h want 61", slot(3)); end
      n_cmp++; if (bus.fun_rdy_frm_exe[3] !== 1'b1) begin n_bad++; $display("FAIL adr_rdy got %b want 1", bus.fun_rdy_frm_exe[3]); end
      bus.mem_ack = 1'b1;
      step();
      idle_inputs();
      n_cmp++; if (slot(3) !== 7'h0) begin n_bad++; $display("FAIL adr_idle_ack got %h want 0", slot(3)); end
   endtask

   task automatic test_flush();
      bus.iss_vld = 4'b1001; bus.iss_prg = {6'd20, 12'd0, 6'd3};
      step();
      idle_inputs();
      step();
      // mult is one edge from its pulse, addr pending: flush with ack and an ALU issue
      bus.fls_frm_rob = 7'h45; bus.mem_ack = 1'b1;
      bus.iss_vld = 4'b0010; bus.iss_prg = {12'd0, 6'd2, 6'd0};
      step();
      idle_inputs();
      n_cmp++; if (bus.prg_rdy_frm_exe !== 28'h0) begin n_bad++; $display("FAIL fls_prg got %h want 0", bus.prg_rdy_frm_exe); end
      n_cmp++; if (bus.fun_rdy_frm_exe !== 4'b1111) begin n_bad++; $display("FAIL fls_rdy got %b want 1111", bus.fun_rdy_frm_exe); end
      bus.mem_ack = 1'b1;
      for (int t = 0; t < 4; t++) begin
         step();
         n_cmp++; if (bus.prg_rdy_frm_exe !== 28'h0) begin n_bad++; $display("FAIL fls_after[%0d] got %h want 0", t, bus.prg_rdy_frm_exe); end
      end
      idle_inputs();
   endtask

   task automatic test_all4();
      bus.iss_vld = 4'b1111; bus.iss_prg = {6'd4, 6'd3, 6'd2, 6'd1};
      step();
      idle_inputs();
      n_cmp++; if (slot(1) !== 7'h42 || slot(2) !== 7'h43) begin n_bad++; $display("FAIL all4_alu got %h/%h want 42/43", slot(1), slot(2)); end
      n_cmp++; if (bus.fun_rdy_frm_exe !== 4'b0110) begin n_bad++; $display("FAIL all4_rdy got %b want 0110", bus.fun_rdy_frm_exe); end
      step();
      bus.mem_ack = 1'b1;
      step();
      idle_inputs();
      n_cmp++; if (slot(0) !== 7'h41 || slot(3) !== 7'h44) begin n_bad++; $display("FAIL all4_late got %h/%h want 41/44", slot(0), slot(3)); end
      step();
   endtask

   task automatic test_back_to_back();
      logic [8:1] exp_v;
`ifdef FUN_SCH_MUL_EARLY_RDY_EN
      exp_v = 8'b0010_0100;
`else
      exp_v = 8'b0100_0100;
`endif
      bus.iss_vld = 4'b0001; bus.iss_prg = {18'd0, 6'd10};
      for (int t = 1; t <= 8; t++) begin
         step();
         if (t == 6) idle_inputs();
         n_cmp++; if (slot(0) !== (exp_v[t] ? 7'h4A : 7'h00)) begin n_bad++; $display("FAIL b2b T+%0d got %h want %h", t, slot(0), exp_v[t] ? 7'h4A : 7'h00); end
      end
      step();
   endtask

   task automatic test_reset_mid();
      bus.iss_vld = 4'b1001; bus.iss_prg = {6'd8, 12'd0, 6'd8};
      step();
      idle_inputs();
      rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.fun_rdy_frm_exe !== 4'b0000 || bus.prg_rdy_frm_exe !== 28'h0) begin n_bad++; $display("FAIL mid_rst got %b/%h want 0000/0", bus.fun_rdy_frm_exe, bus.prg_rdy_frm_exe); end
      step();
      rst_n = 1'b1;
      bus.mem_ack = 1'b1;
      for (int t = 0; t < 5; t++) begin
         step();
         n_cmp++; if (bus.prg_rdy_frm_exe !== 28'h0 || bus.fun_rdy_frm_exe !== 4'b1111) begin n_bad++; $display("FAIL mid_rel[%0d] got %h/%b want 0/1111", t, bus.prg_rdy_frm_exe, bus.fun_rdy_frm_exe); end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_alu();
      test_mult();
      test_addr();
      test_flush();
      test_all4();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fun_sch.md
FUN_SCH -- requirements
Module: fun_sch

Interface
REQ-001 Parameter PRG_IDX_BITS, default 6, physical register index width.
REQ-002 Parameter PRG_SIG_WIDTH, default 7, completion slot width: valid bit plus PRG_IDX_BITS index.
REQ-003 Parameter MUL_LAT, default 3, multiplier latency in cycles; legal range 2..15.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 iss_vld  input  4  per-unit issue strobe: bit0 mult, bit1 alu1, bit2 alu2, bit3 addr.
REQ-007 iss_prg  input  4*PRG_IDX_BITS  destination preg per unit, same slot order, unit k at [k*6+5:k*6].
REQ-008 fls_frm_rob  input  PRG_SIG_WIDTH  flush request, bit6 valid, bits5:0 branch index (ignored).
REQ-009 mem_ack  input  1  memory access complete for the in-flight addr op.
REQ-010 fun_rdy_frm_exe  output  4  per-unit ready-to-accept, registered, same bit order.
REQ-011 prg_rdy_frm_exe  output  4*PRG_SIG_WIDTH  completion broadcast: slot k at [k*7+6:k*7], bit k*7+6 valid, lower 6 bits preg.

Function
REQ-012 The block accepts an issue on unit k only when iss_vld[k]=1 and fun_rdy_frm_exe[k]=1 in the same cycle; it silently drops issues to a not-ready unit.
REQ-013 ALU units (1,2) are always ready outside reset; an accepted ALU issue in cycle T produces slot valid with iss_prg in cycle T+1, for one cycle.
REQ-014 Mult FSM: states M_IDLE, M_BUSY; accepted issue loads 4-bit counter with MUL_LAT-1, latches preg, enters M_BUSY, and drives fun_rdy[0]=0 from T+1.
REQ-015 In M_BUSY, the counter decrements each cycle; at counter==0 the block emits slot0 valid in the following cycle and returns to M_IDLE; net result: issue at T yields slot0 valid at T+MUL_LAT.
REQ-016 Addr FSM: states A_IDLE, A_WAIT; accepted issue latches preg, enters A_WAIT, and drives fun_rdy[3]=0 from T+1; mem_ack in A_WAIT at cycle T yields slot3 valid at T+1, return to A_IDLE, fun_rdy[3]=1 at T+1.
REQ-017 The block ignores mem_ack in A_IDLE.
REQ-018 Every prg_rdy slot is a single-cycle pulse; when not valid, the slot equals all zeros.
REQ-019 Flush (fls_frm_rob[6]=1) in cycle T: the block ignores all issues in T, forces both FSMs to IDLE, and suppresses every completion pulse due at T+1, including a simultaneous mem_ack or mult counter==0; fun_rdy_frm_exe=4'b1111 at T+1.
REQ-020 Flush has priority over every other event in the same cycle.
REQ-021 All four units operate independently; simultaneous issues to all four are accepted in one cycle.

Reset
REQ-022 While rst_n=0: fun_rdy_frm_exe=4'b0000, prg_rdy_frm_exe=0, FSMs in IDLE, counter=0, latched pregs=0.
REQ-023 On the first rising edge after rst_n deasserts, fun_rdy_frm_exe becomes 4'b1111.
REQ-024 Reset asserted mid-operation discards any in-flight mult/addr op; it produces no completion after release.

Configuration
REQ-025 Macro FUN_SCH_MUL_EARLY_RDY_EN: when defined, fun_rdy[0]=1 in the same cycle as the slot0 completion pulse, and the block accepts an issue in that cycle (back-to-back multiplies every MUL_LAT cycles); when undefined, fun_rdy[0] reasserts one cycle after the completion pulse (one multiply per MUL_LAT+1 cycles).

Verification
REQ-026 Reset release, no stimulus -> fun_rdy=4'b1111 one cycle after release, prg_rdy=0 throughout.
REQ-027 iss_vld=4'b0110, iss_prg alu1=5, alu2=9 at T -> at T+1 slot1=7'h45, slot2=7'h49, slot0/3=0; at T+2 all slots 0.
REQ-028 MUL_LAT=3, mult issue preg=12 at T, second mult issue at T+1 -> fun_rdy[0]=0 T+1..T+3, second issue dropped, slot0=7'h4C at T+3 only.
REQ-029 Addr issue preg=33 at T, mem_ack at T+4 -> fun_rdy[3]=0 T+1..T+4, slot3=7'h61 at T+5, fun_rdy[3]=1 at T+5.
REQ-030 Mult in flight, flush and mem_ack in same cycle T with addr pending -> no slot valid at T+1, fun_rdy=4'b1111 at T+1, later mem_ack ignored.
REQ-031 With FUN_SCH_MUL_EARLY_RDY_EN, MUL_LAT=3, mult issues at T and T+3 -> both accepted, slot0 valid at T+3 and T+6.
